tiled_frag_iterator: RTL and testbench

Parametrised fragment iterator for the triangle rasterizer. It accepts one axis-aligned bounding box of unsigned integer pixel coordinates from the setup stage and emits one (x, y) fragment per accepted downstream handshake. It supports scanline (raster) order and, optionally, square-tile order for cache-friendly traversal. It sits between triangle setup and the edge-function / fragment-test stage.

---
 rtl/tiled_frag_iterator.sv | 152 +++++++++++++++
 tb/tb_tiled_frag_iterator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiled_frag_iterator.sv
// Fragment iterator: walks an inclusive bounding box in raster order, or in aligned
// square-tile order when built with TILED_FRAG_ITER_TILE_EN (mode input selects).
module tiled_frag_iterator #(
    parameter int COORD_W   = 10,
    parameter int TILE_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nd,
    output logic               us_rfd,
    input  logic [COORD_W-1:0] min_x,
    input  logic [COORD_W-1:0] max_x,
    input  logic [COORD_W-1:0] min_y,
    input  logic [COORD_W-1:0] max_y,
    input  logic               mode,
    input  logic               ds_rfd,
    output logic               rdy,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    typedef enum logic {IDLE, ITER} state_t;

    localparam logic [COORD_W-1:0] ONE = 1;

    state_t             state_reg, state_next;
    logic [COORD_W-1:0] x_reg, y_reg;
    logic [COORD_W-1:0] min_x_reg, max_x_reg, min_y_reg, max_y_reg;
    logic [COORD_W-1:0] x_step, y_step;
    logic               box_ok, accept, advance, at_last;

    assign box_ok  = (min_x <= max_x) && (min_y <= max_y);
    assign accept  = nd && us_rfd;
    assign advance = rdy && ds_rfd;
    // (max_x, max_y) is the final pixel in both orders, so one test serves both
    assign at_last = (x_reg == max_x_reg) && (y_reg == max_y_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && box_ok) state_next = ITER;
            ITER:    if (advance && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        us_rfd = (state_reg == IDLE) && !rst;
        rdy    = (state_reg == ITER);
        last   = (state_reg == ITER) && at_last;
        x      = x_reg;
        y      = y_reg;
    end

`ifdef TILED_FRAG_ITER_TILE_EN
    localparam logic [COORD_W-1:0] TILE_SIZE = ONE << TILE_LOG2;
    localparam logic [COORD_W-1:0] TILE_MASK = ~(TILE_SIZE - ONE);
    localparam logic [COORD_W:0]   TILE_SPAN = {1'b0, TILE_SIZE - ONE};

    logic               mode_reg;
    logic [COORD_W-1:0] tx_reg, ty_reg, tx_step, ty_step;
    logic [COORD_W:0]   x_end_wide, y_end_wide;
    logic [COORD_W-1:0] x_end, y_end, x_start, y_start;

    // Tile end is formed one bit wider so a tile at the top of the range cannot wrap
    assign x_end_wide = {1'b0, tx_reg} + TILE_SPAN;
    assign y_end_wide = {1'b0, ty_reg} + TILE_SPAN;
    assign x_end   = (x_end_wide > {1'b0, max_x_reg}) ? max_x_reg : x_end_wide[COORD_W-1:0];
    assign y_end   = (y_end_wide > {1'b0, max_y_reg}) ? max_y_reg : y_end_wide[COORD_W-1:0];
    assign x_start = (tx_reg > min_x_reg) ? tx_reg : min_x_reg;
    assign y_start = (ty_reg > min_y_reg) ? ty_reg : min_y_reg;

    always_comb begin
        tx_step = tx_reg;
        ty_step = ty_reg;
        if (!mode_reg) begin
            x_step = (x_reg == max_x_reg) ? min_x_reg : x_reg + ONE;
            y_step = (x_reg == max_x_reg) ? y_reg + ONE : y_reg;
        end else if (x_reg != x_end) begin
            x_step = x_reg + ONE;
            y_step = y_reg;
        end else if (y_reg != y_end) begin
            x_step = x_start;
            y_step = y_reg + ONE;
        end else if (x_end == max_x_reg) begin
            // Right edge of the box: wrap to the first tile of the next tile row
            tx_step = min_x_reg & TILE_MASK;
            ty_step = ty_reg + TILE_SIZE;
            x_step  = min_x_reg;
            y_step  = ty_reg + TILE_SIZE;
        end else begin
            tx_step = tx_reg + TILE_SIZE;
            x_step  = tx_reg + TILE_SIZE;
            y_step  = y_start;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = mode ^ (TILE_LOG2 > 0);

    always_comb begin
        x_step = (x_reg == max_x_reg) ? min_x_reg : x_reg + ONE;
        y_step = (x_reg == max_x_reg) ? y_reg + ONE : y_reg;
    end
`endif

    // Registers hold on the final handshake so nothing steps past the box bounds
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            min_x_reg <= '0;
            max_x_reg <= '0;
            min_y_reg <= '0;
            max_y_reg <= '0;
`ifdef TILED_FRAG_ITER_TILE_EN
            mode_reg  <= 1'b0;
            tx_reg    <= '0;
            ty_reg    <= '0;
`endif
        end else if (accept && box_ok) begin
            x_reg     <= min_x;
            y_reg     <= min_y;
            min_x_reg <= min_x;
            max_x_reg <= max_x;
            min_y_reg <= min_y;
            max_y_reg <= max_y;
`ifdef TILED_FRAG_ITER_TILE_EN
            mode_reg  <= mode;
            tx_reg    <= min_x & TILE_MASK;
            ty_reg    <= min_y & TILE_MASK;
`endif
        end else if (advance && !at_last) begin
            x_reg     <= x_step;
            y_reg     <= y_step;
`ifdef TILED_FRAG_ITER_TILE_EN
            tx_reg    <= tx_step;
            ty_reg    <= ty_step;
`endif
        end
    end

endmodule

// File: tb/tb_tiled_frag_iterator.sv
// Scoreboard bench for tiled_frag_iterator: directed boxes push expected fragments,
// a negedge monitor pops and compares on every downstream handshake.
module tb_tiled_frag_iterator;

    localparam int W = 10;

    typedef struct packed {
        logic [W-1:0] fx;
        logic [W-1:0] fy;
        logic         fl;
    } frag_t;

    logic         clk = 1'b0;
    logic         rst, nd, us_rfd, mode, ds_rfd, rdy, last;
    logic [W-1:0] min_x, max_x, min_y, max_y, x, y;

    frag_t exp_q[$];
    int    seq[];
    int    tests    = 0;
    int    fails    = 0;
    int    hs_count = 0;
    int    hs_base;

    always #5 clk = ~clk;

    tiled_frag_iterator #(.COORD_W(W), .TILE_LOG2(1)) dut (
        .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .mode(mode), .ds_rfd(ds_rfd), .rdy(rdy), .x(x), .y(y), .last(last)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_seq(input bit mark_last);
        frag_t f;
        for (int i = 0; i < seq.size(); i += 2) begin
            f.fx = W'(seq[i]);
            f.fy = W'(seq[i+1]);
            f.fl = mark_last && (i == seq.size() - 2);
            exp_q.push_back(f);
        end
    endtask

    task automatic send_box(input int bx0, input int bx1, input int by0, input int by1,
                            input logic m, input bit expect_frag);
        int n;
        @(negedge clk);
        for (n = 0; n < 100 && !us_rfd; n++) @(negedge clk);
        check("us_rfd_before_box", us_rfd, 1);
        min_x = W'(bx0); max_x = W'(bx1); min_y = W'(by0); max_y = W'(by1);
        mode = m; nd = 1'b1;
        @(posedge clk); #1;
        nd = 1'b0;
        min_x = '0; max_x = '0; min_y = '0; max_y = '0; mode = 1'b0;
        @(negedge clk);
        if (expect_frag) begin
            check("first_rdy", rdy, 1);
            check("first_x", x, bx0);
            check("first_y", y, by0);
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && (exp_q.size() != 0 || !us_rfd); n++) @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_us_rfd", us_rfd, 1);
    endtask

    // Monitor: pop on each handshake, and check outputs hold across stalls
    initial begin
        frag_t e;
        frag_t hv;
        logic  held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && rdy) begin
                    tests++;
                    if ({x, y, last} !== hv) begin
                        fails++;
                        $display("FAIL hold: got (%0d,%0d,last=%0d) expected (%0d,%0d,last=%0d)",
                                 x, y, last, hv.fx, hv.fy, hv.fl);
                    end
                end
                held = rdy && !ds_rfd;
                hv   = {x, y, last};
                if (rdy && ds_rfd) begin
                    hs_count++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL frag: got unexpected (%0d,%0d,last=%0d) expected none",
                                 x, y, last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({x, y, last} !== e) begin
                            fails++;
                            $display("FAIL frag: got (%0d,%0d,last=%0d) expected (%0d,%0d,last=%0d)",
                                     x, y, last, e.fx, e.fy, e.fl);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; nd = 1'b0; mode = 1'b0; ds_rfd = 1'b1;
        min_x = '0; max_x = '0; min_y = '0; max_y = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_rdy", rdy, 0);
        check("reset_x", x, 0);
        check("reset_y", y, 0);
        check("reset_last", last, 0);
        check("reset_us_rfd", us_rfd, 0);
        rst = 1'b0;
        @(negedge clk);
        check("us_rfd_after_reset", us_rfd, 1);

        // Raster 2x2 with exact cycle timing
        seq = '{0,0, 1,0, 0,1, 1,1};
        push_seq(1);
        send_box(0, 1, 0, 1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("raster_rdy", rdy, 1);
        end
        @(negedge clk);
        check("raster_us_rfd_n5", us_rfd, 1);
        check("raster_rdy_n5", rdy, 0);

        // Backpressure: ds_rfd 1,0,0,1,1
        hs_base = hs_count;
        seq = '{5,3, 6,3, 7,3};
        push_seq(1);
        send_box(5, 7, 3, 3, 1'b0, 1'b1);
        @(posedge clk); #1; ds_rfd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; ds_rfd = 1'b1;
        wait_drain();
        check("bp_handshakes", hs_count - hs_base, 3);

        // Tiled 4x2, mode=1
`ifdef TILED_FRAG_ITER_TILE_EN
        seq = '{0,0, 1,0, 0,1, 1,1, 2,0, 3,0, 2,1, 3,1};
`else
        seq = '{0,0, 1,0, 2,0, 3,0, 0,1, 1,1, 2,1, 3,1};
`endif
        push_seq(1);
        send_box(0, 3, 0, 1, 1'b1, 1'b1);
        wait_drain();

        // Clipped tiles, plus an nd pulse during ITER that must be ignored
        hs_base = hs_count;
`ifdef TILED_FRAG_ITER_TILE_EN
        seq = '{1,1, 2,1, 1,2, 1,3, 2,2, 2,3, 1,4, 2,4};
`else
        seq = '{1,1, 2,1, 1,2, 2,2, 1,3, 2,3, 1,4, 2,4};
`endif
        push_seq(1);
        send_box(1, 2, 1, 4, 1'b1, 1'b1);
        nd = 1'b1;
        @(posedge clk); #1;
        nd = 1'b0;
        wait_drain();
        check("clip_handshakes", hs_count - hs_base, 8);

        // Empty box
        send_box(4, 3, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("empty_us_rfd", us_rfd, 1);
            check("empty_rdy", rdy, 0);
            @(negedge clk);
        end

        // Boxes touching the top of the coordinate range
        seq = '{1022,1023, 1023,1023};
        push_seq(1);
        send_box(1022, 1023, 1023, 1023, 1'b0, 1'b1);
        wait_drain();
        seq = '{1021,1023, 1022,1023, 1023,1023};
        push_seq(1);
        send_box(1021, 1023, 1023, 1023, 1'b1, 1'b1);
        wait_drain();
        @(negedge clk);
        check("edge_no_extra_rdy", rdy, 0);

        // Reset after the second fragment of a 4x4 box
        seq = '{0,0, 1,0};
        push_seq(0);
        send_box(0, 3, 0, 3, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ds_rfd = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rdy", rdy, 0);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_last", last, 0);
        check("midrst_queue", exp_q.size(), 0);
        rst = 1'b0;
        ds_rfd = 1'b1;
        seq = '{2,5, 3,5};
        push_seq(1);
        send_box(2, 3, 5, 5, 1'b0, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
